// File: rtl/rx_fsm.sv
// Receive-side frame tracker: 16x oversampled start/data/parity/stop sequencing with
// three-sample majority bit voting and triple-redundant state and bit-counter registers.
module rx_fsm #(
   parameter logic [3:0]  BITNUMBER  = 4'd7,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       p_Enable_i,
   input  logic       p_SampleSig_i,
   input  logic       Rx_i,
   input  logic       ParityEnable_i,
   input  logic       ParityOdd_i,
   output logic [4:0] State_o,
   output logic [3:0] BitCounter_o,
   output logic [7:0] Byte_o,
   output logic       p_ByteValid_o,
   output logic       p_ParityErr_o,
   output logic       p_FrameErr_o
);

   localparam int unsigned     SC_W    = $clog2(OVERSAMPLE);
   localparam logic [SC_W-1:0] SC_S7   = SC_W'(7);
   localparam logic [SC_W-1:0] SC_S8   = SC_W'(8);
   localparam logic [SC_W-1:0] SC_S9   = SC_W'(9);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);

   typedef enum logic [4:0] {
      ST_INTERVAL  = 5'b00001,
      ST_STARTBIT  = 5'b00010,
      ST_DATABITS  = 5'b00100,
      ST_PARITYBIT = 5'b01000,
      ST_STOPBIT   = 5'b10000
   } state_t;

   state_t          r_state_a, r_state_b, r_state_c;
   logic [3:0]      r_bc_a, r_bc_b, r_bc_c;
   logic            r_rx_meta, r_rxs;
   logic [SC_W-1:0] r_sc;
   logic            r_s7, r_s8;
   logic [7:0]      r_shift;
   logic            r_par_en, r_par_odd, r_perr;
   logic [7:0]      r_byte;
   logic            r_valid, r_perr_o, r_ferr;

   logic [4:0]      w_state;
   logic [3:0]      w_bc;
   logic            w_vote, w_mid, w_last;
   state_t          w_state_nxt;
   logic [3:0]      w_bc_nxt;
   logic [SC_W-1:0] w_sc_nxt;
   logic            w_start, w_data_wr, w_par_wr, w_done;

   // Bitwise 2-of-3 vote across the redundant copies
   assign w_state = (r_state_a & r_state_b) | (r_state_a & r_state_c) | (r_state_b & r_state_c);
   assign w_bc    = (r_bc_a & r_bc_b) | (r_bc_a & r_bc_c) | (r_bc_b & r_bc_c);

   assign w_vote = (r_s7 & r_s8) | (r_s7 & r_rxs) | (r_s8 & r_rxs);
   assign w_mid  = p_SampleSig_i && (r_sc == SC_S9);
   assign w_last = p_SampleSig_i && (r_sc == SC_LAST);

   always_comb begin
      w_state_nxt = state_t'(w_state);
      w_bc_nxt    = 4'd0;
      w_sc_nxt    = r_sc;
      w_start     = 1'b0;
      w_data_wr   = 1'b0;
      w_par_wr    = 1'b0;
      w_done      = 1'b0;
      if (p_SampleSig_i && (w_state != ST_INTERVAL)) begin
         w_sc_nxt = r_sc + SC_W'(1);
      end
      case (w_state)
         ST_INTERVAL: begin
            if (p_SampleSig_i && !r_rxs && p_Enable_i) begin
               w_state_nxt = ST_STARTBIT;
               w_sc_nxt    = '0;
               w_start     = 1'b1;
            end
         end
         ST_STARTBIT: begin
            if (w_mid && w_vote) begin
               w_state_nxt = ST_INTERVAL;
            end else if (w_last) begin
               w_state_nxt = ST_DATABITS;
            end
         end
         ST_DATABITS: begin
            w_bc_nxt  = w_bc;
            w_data_wr = w_mid;
            if (w_last) begin
               if (w_bc < BITNUMBER) begin
                  w_bc_nxt = w_bc + 4'd1;
               end else begin
                  w_bc_nxt    = 4'd0;
                  w_state_nxt = r_par_en ? ST_PARITYBIT : ST_STOPBIT;
               end
            end
         end
         ST_PARITYBIT: begin
            w_par_wr = w_mid;
            if (w_last) begin
               w_state_nxt = ST_STOPBIT;
            end
         end
         ST_STOPBIT: begin
            // Leave half a bit early so the next start edge can be caught
            if (w_mid) begin
               w_state_nxt = ST_INTERVAL;
               w_done      = 1'b1;
            end
         end
         default: w_state_nxt = ST_INTERVAL;
      endcase
      // Disable aborts any frame in flight, including one finishing this cycle
      if (!p_Enable_i && (w_state != ST_INTERVAL)) begin
         w_state_nxt = ST_INTERVAL;
         w_bc_nxt    = 4'd0;
         w_data_wr   = 1'b0;
         w_par_wr    = 1'b0;
         w_done      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
         r_state_a <= ST_INTERVAL;
         r_state_b <= ST_INTERVAL;
         r_state_c <= ST_INTERVAL;
         r_bc_a    <= 4'd0;
         r_bc_b    <= 4'd0;
         r_bc_c    <= 4'd0;
         r_sc      <= '0;
         r_s7      <= 1'b1;
         r_s8      <= 1'b1;
         r_shift   <= 8'd0;
         r_par_en  <= 1'b0;
         r_par_odd <= 1'b0;
         r_perr    <= 1'b0;
         r_byte    <= 8'd0;
         r_valid   <= 1'b0;
         r_perr_o  <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_rx_meta <= Rx_i;
         r_rxs     <= r_rx_meta;
         r_state_a <= w_state_nxt;
         r_state_b <= w_state_nxt;
         r_state_c <= w_state_nxt;
         r_bc_a    <= w_bc_nxt;
         r_bc_b    <= w_bc_nxt;
         r_bc_c    <= w_bc_nxt;
         r_sc      <= w_sc_nxt;
         if (p_SampleSig_i && (r_sc == SC_S7)) begin
            r_s7 <= r_rxs;
         end
         if (p_SampleSig_i && (r_sc == SC_S8)) begin
            r_s8 <= r_rxs;
         end
         if (w_start) begin
            r_shift   <= 8'd0;
            r_par_en  <= ParityEnable_i;
            r_par_odd <= ParityOdd_i;
            r_perr    <= 1'b0;
         end
         if (w_data_wr) begin
            r_shift[w_bc[2:0]] <= w_vote;
         end
         if (w_par_wr) begin
            r_perr <= ((^r_shift) ^ w_vote) != r_par_odd;
         end
         r_valid  <= w_done;
         r_perr_o <= w_done & r_par_en & r_perr;
         r_ferr   <= w_done & ~w_vote;
         if (w_done) begin
            r_byte <= r_shift;
         end
      end
   end

   assign State_o       = w_state;
   assign BitCounter_o  = w_bc;
   assign Byte_o        = r_byte;
   assign p_ByteValid_o = r_valid;
   assign p_ParityErr_o = r_perr_o;
   assign p_FrameErr_o  = r_ferr;

endmodule

// File: tb/tb_rx_fsm.sv
// Bench for rx_fsm: per-tick line waveforms, a frame-level reference model keyed by tick
// index, and a per-cycle compare process plus literal expectations for directed frames.
module tb_rx_fsm;

   localparam int unsigned DW      = 8;
   localparam logic [4:0]  S_INT   = 5'b00001;
   localparam logic [4:0]  S_START = 5'b00010;
   localparam logic [4:0]  S_DATA  = 5'b00100;
   localparam logic [4:0]  S_PAR   = 5'b01000;
   localparam logic [4:0]  S_STOP  = 5'b10000;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       p_Enable_i = 1'b1;
   logic       p_SampleSig_i = 1'b0;
   logic       Rx_i = 1'b1;
   logic       ParityEnable_i = 1'b0;
   logic       ParityOdd_i = 1'b0;
   logic [4:0] State_o;
   logic [3:0] BitCounter_o;
   logic [7:0] Byte_o;
   logic       p_ByteValid_o;
   logic       p_ParityErr_o;
   logic       p_FrameErr_o;

   rx_fsm dut (
      .clk            (clk),
      .rst            (rst),
      .p_Enable_i     (p_Enable_i),
      .p_SampleSig_i  (p_SampleSig_i),
      .Rx_i           (Rx_i),
      .ParityEnable_i (ParityEnable_i),
      .ParityOdd_i    (ParityOdd_i),
      .State_o        (State_o),
      .BitCounter_o   (BitCounter_o),
      .Byte_o         (Byte_o),
      .p_ByteValid_o  (p_ByteValid_o),
      .p_ParityErr_o  (p_ParityErr_o),
      .p_FrameErr_o   (p_FrameErr_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Line level and enable per oversampling tick of the wave being built
   bit wlv[$];
   bit wen[$];

   ev_t        exp_ev[int];
   logic [4:0] exp_st[int];
   logic [3:0] exp_bc[int];
   int         gtick = 0;
   int         cur_tick = -1;
   int         model_nev = 0;
   logic [7:0] model_last = 8'h00;

   bit         chk_en = 1'b0;
   int         edge_tick = -1;
   logic       en_q = 1'b1;
   logic       rst_q = 1'b1;
   logic [7:0] exp_byte = 8'h00;
   int         n_valid = 0;
   int         n_start_cyc = 0;
   logic [7:0] last_byte = 8'h00;
   logic       last_perr = 1'b0;
   logic       last_ferr = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit maj(input bit a, input bit b, input bit c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic void add_lvl(input bit v, input int n);
      for (int i = 0; i < n; i++) begin
         wlv.push_back(v);
         wen.push_back(1'b1);
      end
   endfunction

   function automatic void add_frame(input logic [7:0] d, input bit pe, input bit pbit, input bit stop);
      add_lvl(1'b0, 16);
      for (int i = 0; i < DW; i++) add_lvl(d[i], 16);
      if (pe) add_lvl(pbit, 16);
      add_lvl(stop, 16);
   endfunction

   // Frame j-slots of 16 ticks from the start tick t0; votes use ticks t0+16j+8..10
   function automatic void model_wave(input int base, input bit pe, input bit po);
      int         len;
      int         nslot;
      int         t;
      int         t0;
      int         u;
      bit         fin;
      bit         v;
      bit         pb;
      logic [7:0] d;
      logic [4:0] st;
      ev_t        ev;
      len   = wlv.size();
      nslot = pe ? 11 : 10;
      t     = 0;
      while (t < len) begin
         if (!(wen[t] && (wlv[t] == 1'b0))) begin
            t++;
            continue;
         end
         t0  = t;
         t   = len;
         d   = 8'h00;
         pb  = 1'b0;
         fin = 1'b0;
         for (int j = 0; j < nslot && !fin; j++) begin
            for (int m = 0; m < 16; m++) begin
               u = t0 + 16 * j + m;
               if (u >= len) begin
                  fin = 1'b1;
                  break;
               end
               if (u > t0 && !wen[u]) begin
                  t   = u;
                  fin = 1'b1;
                  break;
               end
               if (m == 10) begin
                  v = maj(wlv[u-2], wlv[u-1], wlv[u]);
                  if (j == 0 && v) begin
                     t   = u + 1;
                     fin = 1'b1;
                     break;
                  end
                  if (j >= 1 && j <= DW) d[j-1] = v;
                  else if (pe && j == DW + 1) pb = v;
                  if (j == nslot - 1) begin
                     ev.data = d;
                     ev.perr = pe & (((^d) ^ pb) != po);
                     ev.ferr = ~v;
                     exp_ev[base + u] = ev;
                     model_nev++;
                     model_last = d;
                     t   = u + 1;
                     fin = 1'b1;
                     break;
                  end
               end
               if (j == 0) st = S_START;
               else if (j <= DW) st = S_DATA;
               else if (pe && j == DW + 1) st = S_PAR;
               else st = S_STOP;
               exp_st[base + u] = st;
               exp_bc[base + u] = (j >= 1 && j <= DW) ? 4'(j - 1) : 4'd0;
            end
         end
      end
   endfunction

   // One tick every 4 clocks; line and enable change 3 clocks before the tick
   task automatic run_wave(input bit pe, input bit po);
      int base;
      base = gtick;
      model_wave(base, pe, po);
      ParityEnable_i = pe;
      ParityOdd_i    = po;
      for (int i = 0; i < wlv.size(); i++) begin
         @(posedge clk);
         #1;
         p_SampleSig_i = 1'b0;
         Rx_i          = wlv[i];
         p_Enable_i    = wen[i];
         repeat (2) @(posedge clk);
         @(posedge clk);
         #1;
         cur_tick      = base + i;
         p_SampleSig_i = 1'b1;
      end
      @(posedge clk);
      #1;
      p_SampleSig_i = 1'b0;
      p_Enable_i    = 1'b1;
      gtick = base + wlv.size();
      wlv.delete();
      wen.delete();
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      p_SampleSig_i = 1'b0;
      Rx_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_state", 32'(State_o), 32'(S_INT));
      check("rst_bitcnt", 32'(BitCounter_o), 32'd0);
      check("rst_byte", 32'(Byte_o), 32'h00);
      check("rst_valid", 32'(p_ByteValid_o), 32'd0);
      check("rst_perr", 32'(p_ParityErr_o), 32'd0);
      check("rst_ferr", 32'(p_FrameErr_o), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      chk_en = 1'b1;
   endtask

   always @(posedge clk) begin
      edge_tick = p_SampleSig_i ? cur_tick : -1;
      en_q      = p_Enable_i;
      rst_q     = rst;
   end

   always @(negedge clk) begin
      ev_t  e;
      logic exp_v;
      if (rst_q) exp_byte = 8'h00;
      if (chk_en && !rst_q) begin
         exp_v = 1'b0;
         e     = '0;
         if (edge_tick >= 0 && exp_ev.exists(edge_tick)) begin
            exp_v    = 1'b1;
            e        = exp_ev[edge_tick];
            exp_byte = e.data;
         end
         check("valid", 32'(p_ByteValid_o), 32'(exp_v));
         check("parity_err", 32'(p_ParityErr_o), 32'(e.perr));
         check("frame_err", 32'(p_FrameErr_o), 32'(e.ferr));
         check("byte", 32'(Byte_o), 32'(exp_byte));
         if (edge_tick >= 0) begin
            check("state", 32'(State_o), 32'(exp_st.exists(edge_tick) ? exp_st[edge_tick] : S_INT));
            check("bitcnt", 32'(BitCounter_o), 32'(exp_bc.exists(edge_tick) ? exp_bc[edge_tick] : 4'd0));
         end
         if (!en_q) check("abort_state", 32'(State_o), 32'(S_INT));
         if (State_o == S_START) n_start_cyc++;
         if (p_ByteValid_o) begin
            n_valid++;
            last_byte = Byte_o;
            last_perr = p_ParityErr_o;
            last_ferr = p_FrameErr_o;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         v0;
      int         s0;
      int         f0;
      logic [7:0] d;
      bit         pe;
      bit         po;
      bit         pbit;
      bit         stop;
      int         idx;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("init_state", 32'(State_o), 32'(S_INT));
      check("init_bitcnt", 32'(BitCounter_o), 32'd0);
      check("init_byte", 32'(Byte_o), 32'h00);
      check("init_valid", 32'(p_ByteValid_o), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      chk_en = 1'b1;

      // 8N1 0xA5
      v0 = n_valid;
      add_lvl(1'b1, 5);
      add_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      add_lvl(1'b1, 10);
      run_wave(1'b0, 1'b0);
      check("a5_count", 32'(n_valid - v0), 32'd1);
      check("a5_byte", 32'(last_byte), 32'hA5);
      check("a5_perr", 32'(last_perr), 32'd0);
      check("a5_ferr", 32'(last_ferr), 32'd0);
      check("a5_model", 32'(model_last), 32'hA5);
      check("a5_idle", 32'(State_o), 32'(S_INT));

      // 0x3C even parity, correct parity bit then wrong parity bit
      add_lvl(1'b1, 3);
      add_frame(8'h3C, 1'b1, 1'b0, 1'b1);
      add_lvl(1'b1, 10);
      run_wave(1'b1, 1'b0);
      check("3c_byte", 32'(last_byte), 32'h3C);
      check("3c_perr_ok", 32'(last_perr), 32'd0);
      add_lvl(1'b1, 3);
      add_frame(8'h3C, 1'b1, 1'b1, 1'b1);
      add_lvl(1'b1, 10);
      run_wave(1'b1, 1'b0);
      check("3c_perr_bad", 32'(last_perr), 32'd1);

      // 4-tick low glitch on idle line: false start only
      v0 = n_valid;
      s0 = n_start_cyc;
      add_lvl(1'b1, 3);
      add_lvl(1'b0, 4);
      add_lvl(1'b1, 20);
      run_wave(1'b0, 1'b0);
      check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
      check("glitch_saw_start", 32'(n_start_cyc > s0), 32'd1);
      check("glitch_idle", 32'(State_o), 32'(S_INT));

      // 0x55 with stop bit low
      add_lvl(1'b1, 3);
      add_frame(8'h55, 1'b0, 1'b0, 1'b0);
      add_lvl(1'b1, 30);
      run_wave(1'b0, 1'b0);
      check("55_byte", 32'(last_byte), 32'h55);
      check("55_ferr", 32'(last_ferr), 32'd1);

      // 0x00 with one inverted sample (sc=8) in data bit 3
      add_lvl(1'b1, 3);
      f0 = wlv.size();
      add_frame(8'h00, 1'b0, 1'b0, 1'b1);
      wlv[f0 + 16 * 4 + 9] = 1'b1;
      add_lvl(1'b1, 10);
      run_wave(1'b0, 1'b0);
      check("00_byte", 32'(last_byte), 32'h00);
      check("00_ferr", 32'(last_ferr), 32'd0);

      // Enable dropped during data bit 4
      v0 = n_valid;
      add_lvl(1'b1, 3);
      f0 = wlv.size();
      add_frame(8'hC3, 1'b0, 1'b0, 1'b1);
      add_lvl(1'b1, 20);
      for (int i = f0 + 16 * 5 + 5; i < f0 + 170; i++) wen[i] = 1'b0;
      run_wave(1'b0, 1'b0);
      check("abort_no_valid", 32'(n_valid - v0), 32'd0);
      check("abort_byte_held", 32'(Byte_o), 32'h00);

      // Reset mid-frame, then a clean 0x81
      add_lvl(1'b1, 2);
      add_lvl(1'b0, 16);
      add_lvl(1'b1, 16);
      add_lvl(1'b0, 10);
      add_lvl(1'b1, 0);
      run_wave(1'b0, 1'b0);
      check("mid_frame_busy", 32'(State_o), 32'(S_DATA));
      do_reset();
      v0 = n_valid;
      add_lvl(1'b1, 3);
      add_frame(8'h81, 1'b0, 1'b0, 1'b1);
      add_lvl(1'b1, 10);
      run_wave(1'b0, 1'b0);
      check("81_count", 32'(n_valid - v0), 32'd1);
      check("81_byte", 32'(last_byte), 32'h81);

      // Randomized frames, gaps (including back-to-back), parity and stop errors, glitches
      for (int w = 0; w < 6; w++) begin
         pe = 1'($urandom_range(0, 1));
         po = 1'($urandom_range(0, 1));
         add_lvl(1'b1, 3);
         for (int f = 0; f < 5; f++) begin
            d    = 8'($urandom);
            pbit = (^d) ^ po ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 7) != 0);
            add_frame(d, pe, pbit, stop);
            add_lvl(1'b1, int'($urandom_range(0, 4)));
         end
         for (int g = 0; g < 3; g++) begin
            idx = int'($urandom_range(0, wlv.size() - 1));
            wlv[idx] = ~wlv[idx];
         end
         add_lvl(1'b1, 200);
         run_wave(pe, po);
      end
      check("final_idle", 32'(State_o), 32'(S_INT));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
